// File: rtl/wb_regfile_pkg.sv
// Shared defaults and helpers for the writeback register file block.
// Default geometry is a 32-entry, 32-bit register file with a 32-bit write counter.
package wb_regfile_pkg;

    localparam int DEF_ASIZE  = 5;
    localparam int DEF_DSIZE  = 32;
    localparam int DEF_NREG   = 1 << DEF_ASIZE;
    localparam int DEF_WCNT_W = 32;

    // A write lands only outside reset, when enabled, and never on r0.
    function automatic logic is_commit(input logic rst_now,
                                       input logic wen,
                                       input logic addr_nonzero);
        return wen & addr_nonzero & ~rst_now;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bus plus the decode-side read ports and debug counter.
// master drives the pipeline and read addresses; slave is the register file.
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int ASIZE = DEF_ASIZE,
    parameter int DSIZE = DEF_DSIZE,
    parameter int CNT_W = DEF_WCNT_W
) ();

    logic [ASIZE-1:0] waddr_in;
    logic [DSIZE-1:0] aluout_in;
    logic [DSIZE-1:0] memdata_in;
    logic             wen_in;
    logic             memtoreg_in;
    logic [ASIZE-1:0] raddr1;
    logic [ASIZE-1:0] raddr2;
    logic [DSIZE-1:0] rdata1;
    logic [DSIZE-1:0] rdata2;
    logic [DSIZE-1:0] wb_data;
    logic [CNT_W-1:0] wcount;

    modport master (
        output waddr_in, aluout_in, memdata_in, wen_in, memtoreg_in,
        output raddr1, raddr2,
        input  rdata1, rdata2, wb_data, wcount
    );

    modport slave (
        input  waddr_in, aluout_in, memdata_in, wen_in, memtoreg_in,
        input  raddr1, raddr2,
        output rdata1, rdata2, wb_data, wcount
    );

endinterface

// File: rtl/wb_regfile_core.sv
// Raw register storage: async clear, one write port, two unbypassed combinational reads.
// The caller is responsible for never asserting a write to entry 0.
module regfile_core
    import wb_regfile_pkg::*;
#(
    parameter int ASIZE = DEF_ASIZE,
    parameter int DSIZE = DEF_DSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr1_i,
    input  logic [ASIZE-1:0] raddr2_i,
    output logic [DSIZE-1:0] rdata1_o,
    output logic [DSIZE-1:0] rdata2_o
);

    localparam int NREG = 1 << ASIZE;

    logic [DSIZE-1:0] regs_q [NREG];

    // One flop bank per entry so reset can clear every entry in parallel.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else if (we_i && (waddr_i == ASIZE'(gi))) begin
                    regs_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU/load result, commits to the register file,
// serves two bypassed read ports with r0 hardwired to zero, and counts commits.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int ASIZE = DEF_ASIZE,
    parameter int DSIZE = DEF_DSIZE,
    parameter int CNT_W = DEF_WCNT_W
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    logic [DSIZE-1:0] wb_data;
    logic             commit;
    logic [DSIZE-1:0] raw_rdata [2];
    logic [ASIZE-1:0] raddr     [2];
    logic [DSIZE-1:0] rdata     [2];
    logic [CNT_W-1:0] wcount_q;
    logic [CNT_W-1:0] wcount_d;

    assign wb_data = bus.memtoreg_in ? bus.memdata_in : bus.aluout_in;

    // Gating with rst keeps the bypass from leaking data while the array reads zero.
    assign commit = is_commit(rst, bus.wen_in, |bus.waddr_in);

    regfile_core #(
        .ASIZE (ASIZE),
        .DSIZE (DSIZE)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .we_i     (commit),
        .waddr_i  (bus.waddr_in),
        .wdata_i  (wb_data),
        .raddr1_i (bus.raddr1),
        .raddr2_i (bus.raddr2),
        .rdata1_o (raw_rdata[0]),
        .rdata2_o (raw_rdata[1])
    );

    assign raddr[0] = bus.raddr1;
    assign raddr[1] = bus.raddr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            always_comb begin
                rdata[gi] = raw_rdata[gi];
                if (raddr[gi] == '0) begin
                    rdata[gi] = '0;
                end else if (commit && (bus.waddr_in == raddr[gi])) begin
                    rdata[gi] = wb_data;
                end
            end
        end
    endgenerate

    always_comb begin
        wcount_d = wcount_q;
        if (commit) begin
            wcount_d = wcount_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcount_q <= '0;
        end else begin
            wcount_q <= wcount_d;
        end
    end

    assign bus.wb_data = wb_data;
    assign bus.rdata1  = rdata[0];
    assign bus.rdata2  = rdata[1];
    assign bus.wcount  = wcount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a 32-bit-counter instance for function,
// plus a 4-bit-counter instance for the wrap case.
module tb_wb_regfile;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_regfile_if #(.ASIZE(5), .DSIZE(32), .CNT_W(32)) bus  ();
    wb_regfile_if #(.ASIZE(5), .DSIZE(32), .CNT_W(4))  bus4 ();

    wb_regfile #(.ASIZE(5), .DSIZE(32), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_regfile #(.ASIZE(5), .DSIZE(32), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.waddr_in = '0; bus.aluout_in = '0; bus.memdata_in = '0;
        bus.wen_in = 1'b0; bus.memtoreg_in = 1'b0;
        bus.raddr1 = '0; bus.raddr2 = '0;
        bus4.waddr_in = '0; bus4.aluout_in = '0; bus4.memdata_in = '0;
        bus4.wen_in = 1'b0; bus4.memtoreg_in = 1'b0;
        bus4.raddr1 = '0; bus4.raddr2 = '0;
        repeat (2) @(negedge clk);

        // Reset state; wb_data still follows inputs.
        bus.raddr1 = 5'd5; bus.aluout_in = 32'h77;
        #1;
        check("rst_rdata1", bus.rdata1, 32'h0);
        check("rst_wcount", bus.wcount, 32'h0);
        check("rst_wbdata", bus.wb_data, 32'h77);

        // Commit attempted while rst is high must be discarded.
        bus.wen_in = 1'b1; bus.waddr_in = 5'd5;
        #1;
        check("rst_no_bypass", bus.rdata1, 32'h0);
        @(negedge clk);
        rst = 1'b0; bus.wen_in = 1'b0;
        #1;
        check("rst_discard_r5", bus.rdata1, 32'h0);
        check("rst_discard_cnt", bus.wcount, 32'h0);
        $display("txn reset: rdata1=%h wcount=%0d", bus.rdata1, bus.wcount);

        // Mux select memdata, commit to r3.
        bus.aluout_in = 32'h11; bus.memdata_in = 32'h22; bus.memtoreg_in = 1'b1;
        bus.wen_in = 1'b1; bus.waddr_in = 5'd3; bus.raddr1 = 5'd3;
        #1;
        check("mux_mem_wbdata", bus.wb_data, 32'h22);
        check("mux_mem_bypass", bus.rdata1, 32'h22);
        @(posedge clk); #1;
        bus.wen_in = 1'b0; #1;
        check("mux_mem_r3", bus.rdata1, 32'h22);
        check("mux_mem_cnt", bus.wcount, 32'd1);
        $display("txn commit r3 mem: rdata1=%h wcount=%0d", bus.rdata1, bus.wcount);

        // Mux select aluout, commit to r3.
        @(negedge clk);
        bus.memtoreg_in = 1'b0; bus.wen_in = 1'b1;
        #1;
        check("mux_alu_wbdata", bus.wb_data, 32'h11);
        @(posedge clk); #1;
        bus.wen_in = 1'b0; #1;
        check("mux_alu_r3", bus.rdata1, 32'h11);
        check("mux_alu_cnt", bus.wcount, 32'd2);
        $display("txn commit r3 alu: rdata1=%h wcount=%0d", bus.rdata1, bus.wcount);

        // Both ports bypass on the same register.
        @(negedge clk);
        bus.raddr1 = 5'd7; bus.raddr2 = 5'd7; bus.waddr_in = 5'd7;
        bus.aluout_in = 32'hA5A5A5A5; bus.wen_in = 1'b1;
        #1;
        check("byp_rdata1", bus.rdata1, 32'hA5A5A5A5);
        check("byp_rdata2", bus.rdata2, 32'hA5A5A5A5);
        @(posedge clk); #1;
        bus.wen_in = 1'b0; #1;
        check("byp_arr1", bus.rdata1, 32'hA5A5A5A5);
        check("byp_arr2", bus.rdata2, 32'hA5A5A5A5);
        check("byp_cnt", bus.wcount, 32'd3);
        $display("txn bypass r7: rdata1=%h rdata2=%h wcount=%0d", bus.rdata1, bus.rdata2, bus.wcount);

        // Write to r0 is dropped and never bypassed.
        @(negedge clk);
        bus.raddr1 = 5'd0; bus.waddr_in = 5'd0; bus.aluout_in = 32'hFFFF_FFFF; bus.wen_in = 1'b1;
        #1;
        check("r0_before", bus.rdata1, 32'h0);
        check("r0_wbdata", bus.wb_data, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("r0_after", bus.rdata1, 32'h0);
        check("r0_cnt", bus.wcount, 32'd3);
        $display("txn write r0: rdata1=%h wcount=%0d", bus.rdata1, bus.wcount);

        // Disabled write to r4.
        @(negedge clk);
        bus.raddr1 = 5'd4; bus.waddr_in = 5'd4; bus.aluout_in = 32'h55; bus.wen_in = 1'b0;
        #1;
        check("dis_nobypass", bus.rdata1, 32'h0);
        @(posedge clk); #1;
        check("dis_r4", bus.rdata1, 32'h0);
        check("dis_cnt", bus.wcount, 32'd3);
        $display("txn disabled r4: rdata1=%h wcount=%0d", bus.rdata1, bus.wcount);

        // Back-to-back commits to r9.
        @(negedge clk);
        bus.raddr2 = 5'd9; bus.waddr_in = 5'd9; bus.aluout_in = 32'h100; bus.wen_in = 1'b1;
        #1;
        check("b2b_first", bus.rdata2, 32'h100);
        @(negedge clk);
        bus.aluout_in = 32'h200;
        #1;
        check("b2b_second", bus.rdata2, 32'h200);
        @(posedge clk); #1;
        bus.wen_in = 1'b0; #1;
        check("b2b_arr", bus.rdata2, 32'h200);
        check("b2b_cnt", bus.wcount, 32'd5);
        $display("txn b2b r9: rdata2=%h wcount=%0d", bus.rdata2, bus.wcount);

        // r5 <- DEADBEEF, then asynchronous reset mid-cycle.
        @(negedge clk);
        bus.raddr1 = 5'd5; bus.waddr_in = 5'd5; bus.aluout_in = 32'hDEADBEEF; bus.wen_in = 1'b1;
        @(posedge clk); #1;
        bus.wen_in = 1'b0; #1;
        check("rc_r5", bus.rdata1, 32'hDEADBEEF);
        check("rc_cnt", bus.wcount, 32'd6);
        rst = 1'b1; #1;
        check("rc_clear_r5", bus.rdata1, 32'h0);
        check("rc_clear_r9", bus.rdata2, 32'h0);
        check("rc_clear_cnt", bus.wcount, 32'h0);
        $display("txn async reset: rdata1=%h wcount=%0d", bus.rdata1, bus.wcount);
        @(negedge clk);
        rst = 1'b0;

        // Counter wrap on the 4-bit instance: 16 commits -> 0, 17 -> 1.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus4.wen_in = 1'b1; bus4.waddr_in = 5'((i % 31) + 1); bus4.aluout_in = 32'(i);
        end
        @(negedge clk);
        bus4.wen_in = 1'b0; #1;
        check("wrap16_cnt", 32'(bus4.wcount), 32'd0);
        bus4.wen_in = 1'b1; bus4.waddr_in = 5'd20; bus4.aluout_in = 32'h1234;
        @(posedge clk); #1;
        bus4.wen_in = 1'b0; bus4.raddr1 = 5'd20; #1;
        check("wrap17_cnt", 32'(bus4.wcount), 32'd1);
        check("wrap17_r20", bus4.rdata1, 32'h1234);
        $display("txn wrap: wcount=%0d rdata1=%h", bus4.wcount, bus4.rdata1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
